// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
//
// Receives a program image over an 8N1 UART link and writes it word by word
// into the instruction/data block RAM. The CPU is held idle while a load is in
// progress. Sticky status flags record whether the most recent load passed or
// failed.
//
// Packet format (bytes on the wire):
//   0xA5 | N | N words, each BPW bytes, MSB first | checksum
// The checksum is the mod-256 sum of the data bytes only.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   uart_rx    asynchronous serial input, idles high
//   mem_wen    one-cycle RAM write strobe
//   mem_addr   RAM write address (holds its value between strobes)
//   mem_wdata  RAM write data (holds its value between strobes)
//   cpu_hold   high while a load is active
//   load_done  one-cycle pulse when a load ends, pass or fail
//   load_ok    sticky: last load passed, cleared by the next header
//   load_err   sticky: last load failed, cleared by the next header
// -----------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_ok,
    output logic                  load_err
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    // The start-bit check fires once half a bit period has elapsed, which
    // puts every later sample near the centre of its bit.
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(BPW - 1);
    localparam logic [7:0]    HDR_BYTE  = 8'hA5;

    // -------------------------------------------------------------------------
    // Receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    rx_state_t       rx_state_reg;
    logic [1:0]      sync_reg;
    logic            rx_prev_reg;
    logic [TW-1:0]   timer_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      rx_shift_reg;
    logic            byte_valid_reg;
    logic            frame_err_reg;
    logic            rx_sync;

    assign rx_sync = sync_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg       <= 2'b11;
            rx_prev_reg    <= 1'b1;
            rx_state_reg   <= R_IDLE;
            timer_reg      <= '0;
            bit_cnt_reg    <= '0;
            rx_shift_reg   <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], uart_rx};
            rx_prev_reg    <= rx_sync;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            case (rx_state_reg)
                R_IDLE: begin
                    if (rx_prev_reg && !rx_sync) begin
                        rx_state_reg <= R_START;
                        timer_reg    <= '0;
                    end
                end

                R_START: begin
                    if (timer_reg == HALF_LAST) begin
                        timer_reg   <= '0;
                        bit_cnt_reg <= '0;
                        // A line that is high again mid start bit was a glitch.
                        rx_state_reg <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                R_DATA: begin
                    if (timer_reg == BIT_LAST) begin
                        timer_reg    <= '0;
                        rx_shift_reg <= {rx_sync, rx_shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_state_reg <= R_STOP;
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                R_STOP: begin
                    if (timer_reg == BIT_LAST) begin
                        timer_reg <= '0;
                        if (rx_sync) begin
                            byte_valid_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        rx_state_reg <= R_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                default: rx_state_reg <= R_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Word assembly: the newest byte enters the low lane, earlier bytes move
    // up one lane, so the first byte of a word ends up most significant.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] assembled;

    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign assembled[7:0] = rx_shift_reg;
            end else begin : g_up
                assign assembled[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Loader
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        L_HDR,
        L_CNT,
        L_DATA,
        L_SUM
    } ld_state_t;

    ld_state_t             ld_state_reg;
    logic [7:0]            n_reg;
    logic [7:0]            word_cnt_reg;
    logic [BW-1:0]         byte_idx_reg;
    logic [7:0]            csum_reg;
    logic                  mem_wen_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic                  cpu_hold_reg;
    logic                  load_done_reg;
    logic                  load_ok_reg;
    logic                  load_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_reg  <= L_HDR;
            n_reg         <= '0;
            word_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
            csum_reg      <= '0;
            shift_reg     <= '0;
            mem_wen_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_ok_reg   <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            mem_wen_reg   <= 1'b0;
            load_done_reg <= 1'b0;

            // Address advances the cycle after each strobe, so the strobe
            // itself always carries the address of the word being written.
            if (mem_wen_reg) begin
                mem_addr_reg <= mem_addr_reg + ADDR_WIDTH'(1);
            end

            if (frame_err_reg && ld_state_reg != L_HDR) begin
                // Abort; words already written are left in memory.
                load_err_reg  <= 1'b1;
                load_ok_reg   <= 1'b0;
                load_done_reg <= 1'b1;
                cpu_hold_reg  <= 1'b0;
                ld_state_reg  <= L_HDR;
            end else if (byte_valid_reg) begin
                case (ld_state_reg)
                    L_HDR: begin
                        if (rx_shift_reg == HDR_BYTE) begin
                            cpu_hold_reg <= 1'b1;
                            load_ok_reg  <= 1'b0;
                            load_err_reg <= 1'b0;
                            csum_reg     <= '0;
                            ld_state_reg <= L_CNT;
                        end
                    end

                    L_CNT: begin
                        n_reg <= rx_shift_reg;
                        if (rx_shift_reg == 8'd0) begin
                            ld_state_reg <= L_SUM;
                        end else begin
                            mem_addr_reg <= '0;
                            byte_idx_reg <= '0;
                            word_cnt_reg <= '0;
                            ld_state_reg <= L_DATA;
                        end
                    end

                    L_DATA: begin
                        shift_reg <= assembled;
                        csum_reg  <= csum_reg + rx_shift_reg;
                        if (byte_idx_reg == IDX_LAST) begin
                            byte_idx_reg  <= '0;
                            mem_wen_reg   <= 1'b1;
                            mem_wdata_reg <= assembled;
                            word_cnt_reg  <= word_cnt_reg + 8'd1;
                            if (word_cnt_reg == n_reg - 8'd1) begin
                                ld_state_reg <= L_SUM;
                            end
                        end else begin
                            byte_idx_reg <= byte_idx_reg + BW'(1);
                        end
                    end

                    L_SUM: begin
                        load_ok_reg   <= (rx_shift_reg == csum_reg);
                        load_err_reg  <= (rx_shift_reg != csum_reg);
                        load_done_reg <= 1'b1;
                        cpu_hold_reg  <= 1'b0;
                        ld_state_reg  <= L_HDR;
                    end

                    default: ld_state_reg <= L_HDR;
                endcase
            end
        end
    end

    assign mem_wen   = mem_wen_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign load_done = load_done_reg;
    assign load_ok   = load_ok_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_uart_mem_loader.sv
// -----------------------------------------------------------------------------
// Testbench for uart_mem_loader with a 4-clock UART bit period.
// -----------------------------------------------------------------------------
module tb_uart_mem_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_wen;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_ok;
    logic        load_err;

    uart_mem_loader #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_ok  (load_ok),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // Output monitor: logs writes and counts events, sampled on the falling edge.
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          hold_cycles = 0;
    int          bad_drop = 0;
    logic        hold_prev = 1'b0;
    logic [7:0]  wr_addr [0:511];
    logic [15:0] wr_data [0:511];

    always @(negedge clk) begin
        if (mem_wen) begin
            if (wr_cnt < 512) begin
                wr_addr[wr_cnt] <= mem_addr;
                wr_data[wr_cnt] <= mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (load_done) done_cnt <= done_cnt + 1;
        if (cpu_hold) hold_cycles <= hold_cycles + 1;
        // cpu_hold may only fall together with load_done (or under reset).
        if (!reset && hold_prev && !cpu_hold && !load_done) bad_drop <= bad_drop + 1;
        hold_prev <= cpu_hold;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] bytes;    // byte k at bits [8k +: 8]
        int          nbytes;
        int          bad_idx;  // byte sent with a low stop bit, -1 for none
        int          n_wr;
        logic [15:0] wa;       // expected write address w at [8w +: 8]
        logic [31:0] wd;       // expected write data w at [16w +: 16]
        int          done_exp;
        logic        ok_exp;
        logic        err_exp;
        logic        hold_exp;
        logic        seen_exp; // cpu_hold observed at some point
    } vec_t;

    vec_t vecs [7];

    int base_wr, base_done, base_hold, base_bad;
    logic [7:0] sum;

    initial begin
        vecs[0] = '{bytes:64'h00BE_CDAB_3412_02A5, nbytes:7, bad_idx:-1, n_wr:2,
                    wa:16'h0100, wd:32'hABCD_1234, done_exp:1,
                    ok_exp:1'b1, err_exp:1'b0, hold_exp:1'b0, seen_exp:1'b1};
        vecs[1] = '{bytes:64'h00BF_CDAB_3412_02A5, nbytes:7, bad_idx:-1, n_wr:2,
                    wa:16'h0100, wd:32'hABCD_1234, done_exp:1,
                    ok_exp:1'b0, err_exp:1'b1, hold_exp:1'b0, seen_exp:1'b1};
        vecs[2] = '{bytes:64'h0000_0000_003C_FF00, nbytes:3, bad_idx:-1, n_wr:0,
                    wa:16'h0, wd:32'h0, done_exp:0,
                    ok_exp:1'b0, err_exp:1'b1, hold_exp:1'b0, seen_exp:1'b0};
        vecs[3] = '{bytes:64'h0000_0000_0000_00A5, nbytes:3, bad_idx:-1, n_wr:0,
                    wa:16'h0, wd:32'h0, done_exp:1,
                    ok_exp:1'b1, err_exp:1'b0, hold_exp:1'b0, seen_exp:1'b1};
        vecs[4] = '{bytes:64'h0000_0000_0012_01A5, nbytes:3, bad_idx:2, n_wr:0,
                    wa:16'h0, wd:32'h0, done_exp:1,
                    ok_exp:1'b0, err_exp:1'b1, hold_exp:1'b0, seen_exp:1'b1};
        vecs[5] = '{bytes:64'h0000_0000_0000_00A5, nbytes:1, bad_idx:-1, n_wr:0,
                    wa:16'h0, wd:32'h0, done_exp:0,
                    ok_exp:1'b0, err_exp:1'b0, hold_exp:1'b1, seen_exp:1'b1};
        vecs[6] = '{bytes:64'h0000_0000_0000_0000, nbytes:2, bad_idx:-1, n_wr:0,
                    wa:16'h0, wd:32'h0, done_exp:1,
                    ok_exp:1'b1, err_exp:1'b0, hold_exp:1'b0, seen_exp:1'b1};

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_wen",  {31'd0, mem_wen},   32'd0);
        check("rst_addr", {24'd0, mem_addr},  32'd0);
        check("rst_data", {16'd0, mem_wdata}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold},  32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_ok",   {31'd0, load_ok},   32'd0);
        check("rst_err",  {31'd0, load_err},  32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Table-driven packets
        for (int e = 0; e < 7; e++) begin
            base_wr   = wr_cnt;
            base_done = done_cnt;
            base_hold = hold_cycles;
            base_bad  = bad_drop;
            for (int k = 0; k < vecs[e].nbytes; k++) begin
                send_byte(vecs[e].bytes[8*k +: 8], (k != vecs[e].bad_idx));
            end
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_wr_count", e), wr_cnt - base_wr, vecs[e].n_wr);
            for (int w = 0; w < vecs[e].n_wr; w++) begin
                check($sformatf("v%0d_addr%0d", e, w), {24'd0, wr_addr[base_wr + w]},
                      {24'd0, vecs[e].wa[8*w +: 8]});
                check($sformatf("v%0d_data%0d", e, w), {16'd0, wr_data[base_wr + w]},
                      {16'd0, vecs[e].wd[16*w +: 16]});
            end
            check($sformatf("v%0d_done", e), done_cnt - base_done, vecs[e].done_exp);
            check($sformatf("v%0d_ok", e),   {31'd0, load_ok},  {31'd0, vecs[e].ok_exp});
            check($sformatf("v%0d_err", e),  {31'd0, load_err}, {31'd0, vecs[e].err_exp});
            check($sformatf("v%0d_hold", e), {31'd0, cpu_hold}, {31'd0, vecs[e].hold_exp});
            check($sformatf("v%0d_hold_seen", e), {31'd0, (hold_cycles > base_hold)},
                  {31'd0, vecs[e].seen_exp});
            check($sformatf("v%0d_hold_drop", e), bad_drop - base_bad, 0);
        end

        // One-cycle glitch in idle: nothing must change
        base_wr   = wr_cnt;
        base_done = done_cnt;
        base_hold = hold_cycles;
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_wr",   wr_cnt - base_wr, 0);
        check("glitch_done", done_cnt - base_done, 0);
        check("glitch_hold", hold_cycles - base_hold, 0);
        check("glitch_ok",   {31'd0, load_ok}, 32'd1);

        // Reset halfway through word 1
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(8'h34 >> i);
            repeat (CPB) @(negedge clk);
        end
        check("mid_hold_before", {31'd0, cpu_hold}, 32'd1);
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_wen",  {31'd0, mem_wen},   32'd0);
        check("mid_rst_addr", {24'd0, mem_addr},  32'd0);
        check("mid_rst_data", {16'd0, mem_wdata}, 32'd0);
        check("mid_rst_hold", {31'd0, cpu_hold},  32'd0);
        check("mid_rst_done", {31'd0, load_done}, 32'd0);
        check("mid_rst_ok",   {31'd0, load_ok},   32'd0);
        check("mid_rst_err",  {31'd0, load_err},  32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        base_wr   = wr_cnt;
        base_done = done_cnt;
        for (int k = 0; k < 7; k++) send_byte(vecs[0].bytes[8*k +: 8], 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_wr", wr_cnt - base_wr, 2);
        check("post_rst_a0", {24'd0, wr_addr[base_wr]},     32'h00);
        check("post_rst_d0", {16'd0, wr_data[base_wr]},     32'h1234);
        check("post_rst_a1", {24'd0, wr_addr[base_wr + 1]}, 32'h01);
        check("post_rst_d1", {16'd0, wr_data[base_wr + 1]}, 32'hABCD);
        check("post_rst_done", done_cnt - base_done, 1);
        check("post_rst_ok", {31'd0, load_ok}, 32'd1);

        // Full-size load: 255 words, data = address, checksum 0x81
        base_wr   = wr_cnt;
        base_done = done_cnt;
        sum = 8'd0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'hFF, 1'b1);
        for (int i = 0; i < 255; i++) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'(i), 1'b1);
            sum = sum + 8'(i);
        end
        check("big_sum_const", {24'd0, sum}, 32'h81);
        send_byte(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check("big_wr_count", wr_cnt - base_wr, 255);
        for (int i = 0; i < 255; i++) begin
            check($sformatf("big_addr%0d", i), {24'd0, wr_addr[base_wr + i]}, i);
            check($sformatf("big_data%0d", i), {16'd0, wr_data[base_wr + i]}, i);
        end
        check("big_done", done_cnt - base_done, 1);
        check("big_ok",   {31'd0, load_ok},  32'd1);
        check("big_err",  {31'd0, load_err}, 32'd0);
        check("big_hold", {31'd0, cpu_hold}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
